// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// ID-stage hazard control: multi-cycle load-use stalls, mul/div busy tracking
// with HI/LO-use and issue stalls, branch flushes of configurable depth, and a
// saturating stall-cycle counter. Control outputs are combinational from the
// registered state and the current ID/EX inputs; reset forces them to the
// "free-running" values.
module hazard_control_unit #(
    parameter int REG_W       = 5,
    parameter int LOAD_STALLS = 1,
    parameter int MD_LATENCY  = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int PERF_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic              usesRs,
    input  logic              usesRt,
    input  logic [REG_W-1:0]  rtEx,
    input  logic              memReadEx,
    input  logic              isBranch,
    input  logic              mdIssueId,
    input  logic              mdUseId,
    input  logic              mdStartEx,
    output logic              pcWrite,
    output logic              ifIdWrite,
    output logic              ifIdFlush,
    output logic              idExFlush,
    output logic              exMemFlush,
    output logic              mdBusy,
    output logic [PERF_W-1:0] stallCycles
);

    typedef enum logic {IDLE, LOAD_STALL} state_t;

    // The first load-use bubble is the combinational one, so the FSM only
    // covers the remaining LOAD_STALLS-1 cycles.
    localparam logic [2:0] LOAD_INIT  = 3'(LOAD_STALLS - 1);
    localparam logic       MULTI_LOAD = (LOAD_STALLS > 1);
    localparam logic [5:0] MD_INIT    = 6'(MD_LATENCY);
    localparam logic       FL_IDEX    = (FLUSH_DEPTH >= 1);
    localparam logic       FL_EXMEM   = (FLUSH_DEPTH >= 2);
    localparam logic       FL_IFID    = (FLUSH_DEPTH == 3);

    state_t              r_state;
    logic [2:0]          r_loadCnt;
    logic [5:0]          r_mdCnt;
    logic [PERF_W-1:0]   r_stallCycles;

    logic w_run;
    logic w_mdBusy;
    logic w_loadHaz;
    logic w_mdHaz;
    logic w_stall;
    logic w_branch;

    assign w_run     = ~reset;
    assign w_mdBusy  = (r_mdCnt != 6'd0);

    // $zero is never a real producer, so rtEx==0 can not create a hazard.
    assign w_loadHaz = memReadEx && (rtEx != '0) &&
                       ((usesRs && (rs == rtEx)) || (usesRt && (rt == rtEx)));
    assign w_mdHaz   = w_mdBusy && (mdUseId || mdIssueId);
    assign w_stall   = w_run && ((r_state == LOAD_STALL) || w_loadHaz || w_mdHaz);

    // A stalled branch is dropped; the held ID instruction re-presents it.
    assign w_branch  = w_run && isBranch && !w_stall;

    assign pcWrite     = !w_stall;
    assign ifIdWrite   = !w_stall;
    assign idExFlush   = w_stall || (w_branch && FL_IDEX);
    assign exMemFlush  = w_branch && FL_EXMEM;
    assign ifIdFlush   = w_branch && FL_IFID;
    assign mdBusy      = w_run && w_mdBusy;
    assign stallCycles = r_stallCycles;

    // Load-use FSM: holds the pipeline for the extra load bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_loadCnt <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_loadHaz && MULTI_LOAD) begin
                        r_state   <= LOAD_STALL;
                        r_loadCnt <= LOAD_INIT;
                    end
                end
                LOAD_STALL: begin
                    if (r_loadCnt <= 3'd1) begin
                        r_state   <= IDLE;
                        r_loadCnt <= 3'd0;
                    end else begin
                        r_loadCnt <= r_loadCnt - 3'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_loadCnt <= 3'd0;
                end
            endcase
        end
    end

    // Mul/div busy countdown, independent of the load FSM; a new issue reloads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mdCnt <= 6'd0;
        end else if (mdStartEx) begin
            r_mdCnt <= MD_INIT;
        end else if (w_mdBusy) begin
            r_mdCnt <= r_mdCnt - 6'd1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stallCycles <= '0;
        end else if (w_stall && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit. Two instances share one stimulus stream:
//   A: LOAD_STALLS=1, FLUSH_DEPTH=2, PERF_W=32
//   B: LOAD_STALLS=3, FLUSH_DEPTH=3, PERF_W=2 (counter saturates at 3)
// The driver pushes hand-computed expectations; a negedge monitor pops and checks.
module tb_hazard_control_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs = '0, rt = '0, rtEx = '0;
    logic       usesRs = 0, usesRt = 0, memReadEx = 0, isBranch = 0;
    logic       mdIssueId = 0, mdUseId = 0, mdStartEx = 0;

    logic        pcA, ifwA, iffA, idfA, exfA, mdA;
    logic [31:0] stA;
    logic        pcB, ifwB, iffB, idfB, exfB, mdB;
    logic [1:0]  stB;

    always #5 clock = ~clock;

    hazard_control_unit #(.REG_W(5), .LOAD_STALLS(1), .MD_LATENCY(4), .FLUSH_DEPTH(2), .PERF_W(32)) dutA (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .usesRs(usesRs), .usesRt(usesRt),
        .rtEx(rtEx), .memReadEx(memReadEx), .isBranch(isBranch), .mdIssueId(mdIssueId),
        .mdUseId(mdUseId), .mdStartEx(mdStartEx), .pcWrite(pcA), .ifIdWrite(ifwA),
        .ifIdFlush(iffA), .idExFlush(idfA), .exMemFlush(exfA), .mdBusy(mdA), .stallCycles(stA));

    hazard_control_unit #(.REG_W(5), .LOAD_STALLS(3), .MD_LATENCY(4), .FLUSH_DEPTH(3), .PERF_W(2)) dutB (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .usesRs(usesRs), .usesRt(usesRt),
        .rtEx(rtEx), .memReadEx(memReadEx), .isBranch(isBranch), .mdIssueId(mdIssueId),
        .mdUseId(mdUseId), .mdStartEx(mdStartEx), .pcWrite(pcB), .ifIdWrite(ifwB),
        .ifIdFlush(iffB), .idExFlush(idfB), .exMemFlush(exfB), .mdBusy(mdB), .stallCycles(stB));

    // Flag order: {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush, mdBusy}
    localparam logic [5:0] RUN = 6'b110000;
    localparam logic [5:0] STL = 6'b000100;
    localparam logic [5:0] BR2 = 6'b110110;
    localparam logic [5:0] BR3 = 6'b111110;
    localparam logic [5:0] MDB = 6'b000001;

    typedef struct {
        int         ci;
        logic [5:0] fa;
        int         sa;
        logic [5:0] fb;
        int         sb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done  = 0;

    task automatic cyc(input int ci, input logic rst,
                       input logic [4:0] rs_, input logic [4:0] rt_, input logic [4:0] rtEx_,
                       input logic uRs, input logic uRt, input logic mr, input logic br,
                       input logic mdI, input logic mdU, input logic mdS,
                       input logic [5:0] fa, input int sa, input logic [5:0] fb, input int sb);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; rs = rs_; rt = rt_; rtEx = rtEx_;
        usesRs = uRs; usesRt = uRt; memReadEx = mr; isBranch = br;
        mdIssueId = mdI; mdUseId = mdU; mdStartEx = mdS;
        e.ci = ci; e.fa = fa; e.sa = sa; e.fb = fb; e.sb = sb;
        q.push_back(e);
    endtask

    // Monitor: outputs are settled mid-cycle, compare on the falling edge.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] a_f, b_f;
            e   = q.pop_front();
            a_f = {pcA, ifwA, iffA, idfA, exfA, mdA};
            b_f = {pcB, ifwB, iffB, idfB, exfB, mdB};
            n_cmp += 4;
            if (a_f !== e.fa) begin
                n_err++;
                $display("FAIL c%0d flagsA got %b want %b", e.ci, a_f, e.fa);
            end
            if (int'(stA) != e.sa) begin
                n_err++;
                $display("FAIL c%0d stallA got %0d want %0d", e.ci, stA, e.sa);
            end
            if (b_f !== e.fb) begin
                n_err++;
                $display("FAIL c%0d flagsB got %b want %b", e.ci, b_f, e.fb);
            end
            if (int'(stB) != e.sb) begin
                n_err++;
                $display("FAIL c%0d stallB got %0d want %0d", e.ci, stB, e.sb);
            end
        end
    end

    initial begin
        //   ci rst rs rt rtEx uRs uRt mr br mdI mdU mdS  A-flags  sA  B-flags  sB
        // reset masks a live load hazard
        cyc( 0, 1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0, RUN,     0, RUN,     0);
        cyc( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,     0, RUN,     0);
        // lw $5 / add rs=5: A one bubble, B three
        cyc( 2, 0, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0, STL,     0, STL,     0);
        cyc( 3, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, RUN,     1, STL,     1);
        // branch: A flushes depth 2, B is in LOAD_STALL so no EX/MEM flush
        cyc( 4, 0, 5, 0, 5, 1, 0, 0, 1, 0, 0, 0, BR2,     1, STL,     2);
        cyc( 5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, RUN,     1, RUN,     3);
        // $zero and unused rt never hazard
        cyc( 6, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, RUN,     1, RUN,     3);
        cyc( 7, 0, 3, 5, 5, 1, 0, 1, 0, 0, 0, 0, RUN,     1, RUN,     3);
        // rt hazard; B counter saturates; mul/div starts
        cyc( 8, 0, 3, 5, 5, 0, 1, 1, 0, 0, 0, 1, STL,     1, STL,     3);
        cyc( 9, 0, 3, 5, 5, 0, 1, 0, 0, 0, 0, 0, RUN|MDB, 2, STL|MDB, 3);
        // async reset mid-LOAD_STALL with MDU busy
        cyc(10, 1, 3, 5, 5, 0, 1, 0, 0, 0, 0, 0, RUN,     0, RUN,     0);
        cyc(11, 0, 3, 5, 5, 0, 1, 0, 0, 0, 0, 0, RUN,     0, RUN,     0);
        // mult in EX, mfhi in ID from the next cycle
        cyc(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUN,     0, RUN,     0);
        cyc(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL|MDB, 0, STL|MDB, 0);
        cyc(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL|MDB, 1, STL|MDB, 1);
        cyc(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL|MDB, 2, STL|MDB, 2);
        cyc(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL|MDB, 3, STL|MDB, 3);
        cyc(17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUN,     4, RUN,     3);
        // clean branch, depth 2 vs 3
        cyc(18, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, BR2,     4, BR3,     3);
        // back-to-back mul/div issue reloads the busy count
        cyc(19, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUN,     4, RUN,     3);
        cyc(20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, STL|MDB, 4, STL|MDB, 3);
        cyc(21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN|MDB, 5, RUN|MDB, 3);
        cyc(22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN|MDB, 5, RUN|MDB, 3);
        cyc(23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN|MDB, 5, RUN|MDB, 3);
        cyc(24, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN|MDB, 5, RUN|MDB, 3);
        cyc(25, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,     5, RUN,     3);
        // stall beats branch
        cyc(26, 0, 7, 0, 7, 1, 0, 1, 1, 0, 0, 0, STL,     5, STL,     3);
        cyc(27, 0, 7, 0, 7, 1, 0, 0, 0, 0, 0, 0, RUN,     6, STL,     3);
        cyc(28, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,     6, STL,     3);
        cyc(29, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,     6, RUN,     3);
        done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!done && budget < 200) begin
            @(posedge clock);
            budget++;
        end
        repeat (2) @(posedge clock);
        n_cmp++;
        if (!done || q.size() != 0) begin
            n_err++;
            $display("FAIL drain done=%0d pending=%0d want done=1 pending=0", done, q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
